// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer holding long-latency results until a free WB slot drains them.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                din,
  input  logic                   pop,
  output wb_req_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and queued
// long-latency results; requests a bubble when a queued result starves.
//
// state  | meaning
// NORMAL | pipeline owns the port; queued results drain into idle slots
// STALL  | FIFO head waited MAX_WAIT cycles; bubble requested until it pops
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_regwrite_i,
  input  logic [REG_ADDR_W-1:0]  wb_rd_i,
  input  logic [XLEN-1:0]        wb_data_i,
  input  logic                   mc_valid_i,
  output logic                   mc_ready_o,
  input  logic [REG_ADDR_W-1:0]  mc_rd_i,
  input  logic [XLEN-1:0]        mc_data_i,
  output logic                   rf_we_o,
  output logic [REG_ADDR_W-1:0]  rf_waddr_o,
  output logic [XLEN-1:0]        rf_wdata_o,
  output logic                   stall_req_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  wb_req_t     head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        real_wb;
  arb_state_t  state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;

  assign mc_ready_o = !rst && !full;
  // Results for x0 are acknowledged but never queued.
  assign push       = mc_valid_i && mc_ready_o && (mc_rd_i != '0);
  assign real_wb    = wb_regwrite_i && (wb_rd_i != '0);
  assign pop        = !real_wb && !empty;
  assign wait_nxt   = wait_cnt + 1'b1;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ('{rd: mc_rd_i, data: mc_data_i}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      stall_req_o <= 1'b0;
      state       <= NORMAL;
      wait_cnt    <= '0;
    end else begin
      if (real_wb) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= wb_rd_i;
        rf_wdata_o <= wb_data_i;
      end else if (pop) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= head.rd;
        rf_wdata_o <= head.data;
      end else begin
        rf_we_o    <= 1'b0;
      end

      case (state)
        NORMAL: begin
          if (empty || pop) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WW'(MAX_WAIT)) begin
              state       <= STALL;
              stall_req_o <= 1'b1;
            end
          end
        end
        STALL: begin
          // Stay here while the pipeline ignores the request; head is retained.
          if (pop) begin
            state       <= NORMAL;
            wait_cnt    <= '0;
            stall_req_o <= 1'b0;
          end
        end
        default: begin
          state       <= NORMAL;
          wait_cnt    <= '0;
          stall_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus starvation and reset sequences.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_regwrite_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        mc_valid_i = 1'b0;
  logic        mc_ready_o;
  logic [4:0]  mc_rd_i = '0;
  logic [31:0] mc_data_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_req_o;
  logic [1:0]  fifo_count_o;

  int n_total = 0;
  int n_pass  = 0;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_regwrite_i(wb_regwrite_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .mc_valid_i   (mc_valid_i),
    .mc_ready_o   (mc_ready_o),
    .mc_rd_i      (mc_rd_i),
    .mc_data_i    (mc_data_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .stall_req_o  (stall_req_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_v;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic wwe, logic [4:0] wrd, logic [31:0] wd,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic ewe, logic [4:0] ea, logic [31:0] ed,
                              logic [1:0] ec, logic er, logic es);
    vec_t v;
    v.wb_we = wwe; v.wb_rd = wrd; v.wb_data = wd;
    v.mc_v = mv; v.mc_rd = mrd; v.mc_data = md;
    v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
    v.e_cnt = ec; v.e_rdy = er; v.e_stall = es;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(logic wwe, logic [4:0] wrd, logic [31:0] wd,
                       logic mv, logic [4:0] mrd, logic [31:0] md);
    wb_regwrite_i = wwe; wb_rd_i = wrd; wb_data_i = wd;
    mc_valid_i = mv; mc_rd_i = mrd; mc_data_i = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0,     1, 3, 32'hDEAD,  0, 0, 0,          1, 1, 0);
    vecs[1]  = mk(0, 0, 0,     0, 0, 0,         1, 3, 32'hDEAD,   0, 1, 0);
    vecs[2]  = mk(0, 0, 0,     0, 0, 0,         0, 3, 32'hDEAD,   0, 1, 0);
    vecs[3]  = mk(1, 9, 32'h44, 1, 7, 32'h22,   1, 9, 32'h44,     1, 1, 0);
    vecs[4]  = mk(1, 5, 32'h11, 0, 0, 0,        1, 5, 32'h11,     1, 1, 0);
    vecs[5]  = mk(0, 0, 0,     0, 0, 0,         1, 7, 32'h22,     0, 1, 0);
    vecs[6]  = mk(1, 0, 32'h99, 1, 0, 32'h77,   0, 7, 32'h22,     0, 1, 0);
    vecs[7]  = mk(1, 1, 32'hA1, 1, 10, 32'h100, 1, 1, 32'hA1,     1, 1, 0);
    vecs[8]  = mk(1, 2, 32'hA2, 1, 11, 32'h101, 1, 2, 32'hA2,     2, 0, 0);
    vecs[9]  = mk(1, 1, 32'hA3, 1, 12, 32'h102, 1, 1, 32'hA3,     2, 0, 0);
    vecs[10] = mk(0, 0, 0,     1, 13, 32'h103,  1, 10, 32'h100,   1, 1, 0);
    vecs[11] = mk(1, 4, 32'h55, 1, 0, 32'h104,  1, 4, 32'h55,     1, 1, 0);
    vecs[12] = mk(0, 0, 0,     1, 14, 32'h200,  1, 11, 32'h101,   1, 1, 0);
    vecs[13] = mk(0, 0, 0,     0, 0, 0,         1, 14, 32'h200,   0, 1, 0);

    #2;
    check("ready_in_reset", mc_ready_o, 0);
    #10 rst = 1'b0;
    #1;
    check("rst_we", rf_we_o, 0);
    check("rst_addr", rf_waddr_o, 0);
    check("rst_data", rf_wdata_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_stall", stall_req_o, 0);
    check("rst_ready_after", mc_ready_o, 1);
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data,
            vecs[i].mc_v, vecs[i].mc_rd, vecs[i].mc_data);
      tick();
      check($sformatf("v%0d_we", i),    rf_we_o,      vecs[i].e_we);
      check($sformatf("v%0d_addr", i),  rf_waddr_o,   vecs[i].e_addr);
      check($sformatf("v%0d_data", i),  rf_wdata_o,   vecs[i].e_data);
      check($sformatf("v%0d_count", i), fifo_count_o, vecs[i].e_cnt);
      check($sformatf("v%0d_ready", i), mc_ready_o,   vecs[i].e_rdy);
      check($sformatf("v%0d_stall", i), stall_req_o,  vecs[i].e_stall);
    end

    // Starvation: one queued result while the pipeline writes every cycle.
    drive(1, 1, 32'h1000, 1, 20, 32'hBEEF);
    tick();
    check("starve_push_count", fifo_count_o, 1);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 32'h1000 + k, 0, 0, 0);
      tick();
      check($sformatf("starve_w%0d_stall", k), stall_req_o, (k == 8) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h2000 + k, 0, 0, 0);
      tick();
      check($sformatf("violate%0d_stall", k), stall_req_o, 1);
      check($sformatf("violate%0d_count", k), fifo_count_o, 1);
      check($sformatf("violate%0d_data", k), rf_wdata_o, 32'h2000 + k);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("bubble_we", rf_we_o, 1);
    check("bubble_addr", rf_waddr_o, 20);
    check("bubble_data", rf_wdata_o, 32'hBEEF);
    check("bubble_count", fifo_count_o, 0);
    check("bubble_stall", stall_req_o, 0);
    tick();
    check("after_bubble_we", rf_we_o, 0);
    check("after_bubble_stall", stall_req_o, 0);

    // Reset asserted mid-cycle with one result queued and a write in flight.
    drive(1, 6, 32'h66, 1, 8, 32'h88);
    tick();
    check("pre_rst_we", rf_we_o, 1);
    check("pre_rst_count", fifo_count_o, 1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_we", rf_we_o, 0);
    check("midrst_stall", stall_req_o, 0);
    check("midrst_count", fifo_count_o, 0);
    check("midrst_ready", mc_ready_o, 0);
    #1 rst = 1'b0;
    #1;
    check("postrst_ready", mc_ready_o, 1);
    tick();
    check("postrst_we", rf_we_o, 0);
    check("postrst_count", fifo_count_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (WB result mux output) and a long-latency unit (multiply/divide) that returns results out of band.
- Long-latency results are queued in a small FIFO and drained into idle WB slots.
- If a queued result starves, the block requests a one-cycle pipeline bubble.
- Sits between the WB stage and the register file write port.

Parameters:
DEPTH, 2, FIFO entries for long-latency results (power of two, >=2)
MAX_WAIT, 8, cycles a non-empty FIFO head may wait before a bubble is requested (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_regwrite_i  in  1  pipeline WB slot writes a register this cycle
wb_rd_i  in  5  pipeline destination register
wb_data_i  in  32  pipeline write data (WB mux output)
mc_valid_i  in  1  long-latency result valid
mc_ready_o  out  1  FIFO can accept a result
mc_rd_i  in  5  long-latency destination register
mc_data_i  in  32  long-latency result data
rf_we_o  out  1  register-file write enable (registered)
rf_waddr_o  out  5  register-file write address (registered)
rf_wdata_o  out  32  register-file write data (registered)
stall_req_o  out  1  request one WB bubble from hazard unit
fifo_count_o  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, stall_req_o=0.
  - FIFO empty, fifo_count_o=0, wait counter 0, FSM in NORMAL.
  - mc_ready_o=0 while rst is high.
- mc_ready_o = !rst && (count != DEPTH), combinational from the registered count.
  - No pass-through: a pop in the same cycle does not make a full FIFO ready.
- Accept on mc_valid_i && mc_ready_o.
  - mc_rd_i==0 is accepted and discarded (x0); it is not enqueued.
- Pipeline write is "real" when wb_regwrite_i && wb_rd_i!=0.
- Arbitration each cycle, priority order:
  1. Real pipeline write -> rf_* <= {1, wb_rd_i, wb_data_i}.
  2. Else FIFO non-empty -> pop head; rf_* <= {1, head.rd, head.data}.
  3. Else rf_we_o <= 0; rf_waddr_o and rf_wdata_o hold.
- Latency:
  - Pipeline write in cycle N appears on rf_* in cycle N+1.
  - Long-latency result handshaken in cycle N becomes the head in N+1 and reaches rf_* in N+2 at the earliest.
  - There is no bypass from mc_* to rf_*.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Entries leave in strict arrival order.
- Starvation FSM:
  - NORMAL:
    - Wait counter increments each cycle the FIFO is non-empty and not popped.
    - Counter clears on any pop, or when the FIFO is empty.
    - When the counter reaches MAX_WAIT -> STALL.
  - STALL:
    - stall_req_o=1; the hazard unit must insert one WB bubble.
    - On a pop -> NORMAL, counter cleared, stall_req_o deasserts in the next cycle.
    - If the pipeline still writes (no bubble), remain in STALL with stall_req_o held high.
  - stall_req_o is registered from the FSM state.
- Reset mid-operation: queued results are lost and any in-flight rf write is dropped. The issue logic is reset in the same cycle.
- WAW ordering between a pending long-latency rd and a younger pipeline write to the same rd is prevented by the upstream scoreboard. This block does not check it.

Decomposition:
- Shared package wb_pkg:
  - REG_ADDR_W=5 and XLEN=32.
  - typedef wb_req_t {rd[4:0], data[31:0]}.
  - Arbiter FSM state enum {NORMAL, STALL}.
- One sub-module: wb_result_fifo (parameter DEPTH), with push/pop/full/empty/count and wrapping pointers.
- Arbitration, output registers and FSM live in the top module.

Test Plan:
- Reset: assert rst mid-cycle with count=1 -> rf_we_o=0, stall_req_o=0, fifo_count_o=0, mc_ready_o=0 immediately; mc_ready_o=1 after release.
- Pipeline priority: wb_regwrite_i=1, rd=5, data=0x11 while the FIFO holds {rd=7, 0x22} -> cycle+1 rf={1,5,0x11}. The pipeline goes idle next cycle -> the following cycle rf={1,7,0x22}.
- Idle drain latency: FIFO empty, pipeline idle, mc handshake {rd=3, 0xDEAD} in cycle N -> rf={1,3,0xDEAD} in N+2; rf_we_o=0 in N+1.
- Full and x0: push 2 results with the pipeline writing continuously -> fifo_count_o=2, mc_ready_o=0. A third valid is not accepted. A push with mc_rd_i=0 into a non-full FIFO leaves the count unchanged.
- Starvation: FIFO count=1, pipeline writes rd=1 every cycle -> stall_req_o=1 after MAX_WAIT=8 waiting cycles. A bubble cycle pops the head; stall_req_o=0 the next cycle.
- Protocol violation: with stall_req_o=1 the pipeline keeps writing 3 more cycles -> stall_req_o stays 1 and the head is retained. The first bubble drains it.
